// File: rtl/ctrl_sequencer.sv
// Microsequencer: holds a small program of control words and issues one word
// per accepted ready/valid handshake, with NEXT / REPT / JUMP / HALT sequencing.
module ctrl_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [CW+AW+1:0]   load_data,
  input  logic               start,
  input  logic [AW-1:0]      start_addr,
  input  logic               abort,
  input  logic               ctrl_ready,
  output logic               ctrl_valid,
  output logic [CW-1:0]      ctrl_out,
  output logic               busy,
  output logic               done,
  output logic               load_err,
  output logic [AW-1:0]      pc
);

  localparam int IW = CW + 2 + AW;

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_REPT = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   pc_nx;
  logic [AW-1:0]   rep_cnt, rep_nx;
  logic            done_nx;
  logic [IW-1:0]   mem [DEPTH];

  logic [IW-1:0]   word;
  logic [1:0]      op;
  logic [AW-1:0]   arg;
  logic            running;

  assign word    = mem[pc];
  assign op      = word[CW+1:CW];
  assign arg     = word[CW+AW+1:CW+2];
  assign running = (state == RUN);

  // Outputs are decoded only from the state flop and the pc-indexed array,
  // so ctrl_ready never reaches ctrl_valid combinationally.
  assign ctrl_valid = running;
  assign busy       = running;
  assign ctrl_out   = running ? word[CW-1:0] : '0;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    rep_nx   = rep_cnt;
    done_nx  = done;
    if (abort) begin
      // A handshake coincident with abort is consumed downstream but does not advance pc.
      state_nx = IDLE;
      rep_nx   = '0;
      done_nx  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nx = RUN;
            pc_nx    = start_addr;
            rep_nx   = '0;
            done_nx  = 1'b0;
          end
        end
        RUN: begin
          if (ctrl_ready) begin
            case (op)
              OP_NEXT: begin
                pc_nx  = pc + 1'b1;
                rep_nx = '0;
              end
              OP_REPT: begin
                if (rep_cnt == arg) begin
                  pc_nx  = pc + 1'b1;
                  rep_nx = '0;
                end else begin
                  rep_nx = rep_cnt + 1'b1;
                end
              end
              OP_JUMP: begin
                pc_nx  = arg;
                rep_nx = '0;
              end
              default: begin
                state_nx = DONE;
                done_nx  = 1'b1;
                rep_nx   = '0;
              end
            endcase
          end
        end
        default: begin
          state_nx = IDLE;
          rep_nx   = '0;
          done_nx  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      rep_cnt  <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      rep_cnt  <= rep_nx;
      done     <= done_nx;
      load_err <= load_en && running;
    end
  end

  // Program store is cleared on reset so a fresh start always sees NEXT/ctrl 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load_en && !running) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed steps plus randomized programs, checked
// against an expanded issue-sequence model of the loaded program.
module tb_ctrl_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 7;
  localparam int IW    = CW + 2 + AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          abort = 1'b0;
  logic          ctrl_ready = 1'b0;
  logic          ctrl_valid;
  logic [CW-1:0] ctrl_out;
  logic          busy;
  logic          done;
  logic          load_err;
  logic [AW-1:0] pc;

  ctrl_sequencer #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .ctrl_ready (ctrl_ready),
    .ctrl_valid (ctrl_valid),
    .ctrl_out   (ctrl_out),
    .busy       (busy),
    .done       (done),
    .load_err   (load_err),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Program image as the bench believes it is stored.
  int m_ctrl [DEPTH];
  int m_op   [DEPTH];
  int m_arg  [DEPTH];

  // Expected sequence of program addresses issued for one run.
  int exp_q[$];
  bit exp_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      m_ctrl[i] = 0;
      m_op[i]   = 0;
      m_arg[i]  = 0;
    end
  endtask

  task automatic load(input int a, input int c, input int op, input int arg);
    logic [AW-1:0] a4;
    logic [1:0]    op2;
    logic [CW-1:0] c7;
    a4  = AW'(arg);
    op2 = 2'(op);
    c7  = CW'(c);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = {a4, op2, c7};
    step();
    load_en = 1'b0;
    m_ctrl[a] = c % (1 << CW);
    m_op[a]   = op % 4;
    m_arg[a]  = arg % DEPTH;
  endtask

  // Expand the program into the list of addresses issued, one entry per handshake.
  function automatic void build(input int sa, input int maxlen);
    int a;
    exp_q.delete();
    exp_halt = 1'b0;
    a = sa;
    while (exp_q.size() < maxlen + 1) begin
      if (m_op[a] == 0) begin
        exp_q.push_back(a);
        a = (a + 1) % DEPTH;
      end else if (m_op[a] == 1) begin
        for (int k = 0; k <= m_arg[a]; k++) exp_q.push_back(a);
        a = (a + 1) % DEPTH;
      end else if (m_op[a] == 2) begin
        exp_q.push_back(a);
        a = m_arg[a];
      end else begin
        exp_q.push_back(a);
        exp_halt = 1'b1;
        break;
      end
    end
    if (!exp_halt) begin
      while (exp_q.size() > maxlen + 1) void'(exp_q.pop_back());
    end
  endfunction

  // rmode: 0 ready always high, 1 random ready plus stray starts, 2 ready low for cycles 2..4.
  task automatic run(input int sa, input int maxlen, input int rmode, input int load_at);
    int cyc;
    int stop_at;
    bit lerr_exp;
    cyc = 0;
    lerr_exp = 1'b0;
    build(sa, maxlen);
    stop_at = exp_halt ? 0 : 1;
    start_addr = AW'(sa);
    start = 1'b1;
    step();
    start = 1'b0;
    while (exp_q.size() > stop_at && cyc < 400) begin
      chk("valid", ctrl_valid, 1);
      chk("busy", busy, 1);
      chk("done_run", done, 0);
      chk("pc", pc, exp_q[0]);
      chk("ctrl_out", ctrl_out, m_ctrl[exp_q[0]]);
      chk("load_err", load_err, lerr_exp);
      if (rmode == 0)      ctrl_ready = 1'b1;
      else if (rmode == 1) ctrl_ready = ($urandom % 3) != 0;
      else                 ctrl_ready = !(cyc >= 2 && cyc < 5);
      lerr_exp  = (cyc == load_at);
      load_en   = (cyc == load_at);
      load_addr = AW'(2);
      load_data = IW'($urandom);
      start      = (rmode == 1) && (($urandom % 6) == 0);
      start_addr = AW'($urandom);
      step();
      load_en = 1'b0;
      start   = 1'b0;
      if (ctrl_ready) void'(exp_q.pop_front());
      cyc++;
    end
    chk("cycle_budget", cyc < 400, 1);
    ctrl_ready = 1'b0;
    if (exp_halt) begin
      chk("halt_valid", ctrl_valid, 0);
      chk("halt_done", done, 1);
      chk("halt_busy", busy, 0);
      chk("halt_load_err", load_err, lerr_exp);
      step();
      chk("done_held", done, 1);
      chk("valid_held_low", ctrl_valid, 0);
      chk("ctrl_out_idle", ctrl_out, 0);
    end else begin
      chk("pre_abort_valid", ctrl_valid, 1);
      chk("pre_abort_pc", pc, exp_q[0]);
      abort = 1'b1;
      ctrl_ready = 1'b1;
      step();
      abort = 1'b0;
      ctrl_ready = 1'b0;
      chk("abort_valid", ctrl_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_pc_hold", pc, exp_q[0]);
    end
  endtask

  initial begin
    int sa;
    int la;
    int op;
    clear_model();

    // Power-on reset
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_pc", pc, 0);
    rst_n = 1'b1;
    step();

    // Reset with a program loaded clears the store
    load(0, 'h21, 0, 0);
    load(1, 'h45, 1, 2);
    load(2, 'h7F, 3, 0);
    rst_n = 1'b0;
    step();
    clear_model();
    chk("rst2_valid", ctrl_valid, 0);
    chk("rst2_pc", pc, 0);
    chk("rst2_done", done, 0);
    rst_n = 1'b1;
    step();
    run(0, 6, 0, -1);

    // Basic NEXT / REPT / HALT program
    load(0, 'h21, 0, 0);
    load(1, 'h45, 1, 2);
    load(2, 'h7F, 3, 0);
    run(0, 20, 0, -1);
    run(0, 20, 2, -1);

    // Load attempted while running is rejected with a one-cycle error pulse
    run(0, 20, 0, 1);
    chk("word2_kept_op", m_op[2], 3);

    // Wrap from the last word and jump back
    load(15, 'h11, 0, 0);
    load(0, 'h33, 2, 15);
    run(15, 4, 0, -1);

    // start and abort together from IDLE
    start_addr = AW'(0);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_valid", ctrl_valid, 0);
    chk("sa_busy", busy, 0);
    step();
    chk("sa_valid2", ctrl_valid, 0);

    // Asynchronous reset in the middle of a run
    start_addr = AW'(15);
    start = 1'b1;
    step();
    start = 1'b0;
    ctrl_ready = 1'b1;
    step();
    step();
    chk("mid_valid", ctrl_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", ctrl_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_pc", pc, 0);
    ctrl_ready = 1'b0;
    step();
    rst_n = 1'b1;
    clear_model();
    step();
    run(3, 5, 1, -1);

    // Randomized programs
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < DEPTH; w++) begin
        op = int'($urandom % 4);
        load(w, int'($urandom % 128), op, (op == 1) ? int'($urandom % 4) : int'($urandom % 16));
      end
      sa = int'($urandom % 16);
      la = (($urandom % 2) == 0) ? int'($urandom % 3) : -1;
      run(sa, 30, 1, la);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
